conv_relu_stream: RTL

Streaming single-channel 2D convolution engine with optional ReLU. It forms the feature-extraction stage directly upstream of the average-pooling stage. It accepts a raster-ordered IN_W×IN_H frame of signed 16-bit Q(16−FRAC).FRAC pixels and applies a K×K kernel plus bias using line buffers. It emits the (IN_W−K+1)×(IN_H−K+1) valid-region result in raster order, ready to be packed into the pooling stage's flat per-channel input.

---
 rtl/conv_relu_stream.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_relu_stream.sv
// conv_relu_stream: streaming K x K 2D convolution with bias and an optional ReLU.
// A raster-ordered IN_W x IN_H frame enters one pixel per handshake. The
// valid-region results leave in raster order through a two-stage pipeline:
// S1 holds the sum and S2 holds the shifted, saturated, activated pixel.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
// Otherwise the saturated result passes through unchanged.
module conv_relu_stream #(
    parameter int IN_W = 32,
    parameter int IN_H = 32,
    parameter int K    = 5,
    parameter int FRAC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [0:K*K*16-1]   weight_in,
    input  logic signed [15:0]  bias,
    input  logic signed [15:0]  pix_in,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic signed [15:0]  out_pix,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int NTAP  = K * K;
    localparam int SW    = 32 + $clog2(NTAP);
    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;

    localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
    localparam logic signed [SW-1:0] SAT_MIN = -SW'(32768);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   load_cfg;

    logic signed [15:0]     w_in   [NTAP];
    logic signed [15:0]     w_q    [NTAP];
    logic signed [15:0]     bias_q;

    // Window is stored flat: index r*K+c, r=0 is the oldest (top) row,
    // c=K-1 is the newest (rightmost) column.
    logic signed [15:0]     win_q   [NTAP];
    logic signed [15:0]     col_new [K];
    logic signed [31:0]     prod    [NTAP];

    logic                   wv_q, v1_q, v2_q;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic signed [SW-1:0]   shifted;
    logic signed [15:0]     sat;
    logic signed [15:0]     act_d;
    logic signed [15:0]     out_pix_q;

    logic                   advance;
    logic                   accept;
    logic                   last_pix;
    logic                   win_hit;

    // Both pipeline stages (and the window-valid flag feeding S1) move together.
    assign advance   = !v2_q || out_ready;
    assign pix_ready = (state_q == S_RUN) && advance;
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = accept && (col_q == COL_W'(IN_W - 1)) && (row_q == ROW_W'(IN_H - 1));
    assign win_hit   = accept && (col_q >= COL_W'(K - 1)) && (row_q >= ROW_W'(K - 1));

    assign out_pix   = out_pix_q;
    assign out_valid = v2_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    genvar gi;

    // Unpack the weight bus; (r,c) lives at slice (r*K+c)*16.
    generate
        for (gi = 0; gi < NTAP; gi++) begin : g_wunpack
            assign w_in[gi] = weight_in[gi*16 +: 16];
        end
    endgenerate

    // Line buffers: buffer gi holds the row gi+1 rows above the incoming one.
    // The read is registered and pre-addressed with the next column, so the
    // data for the current column is ready when its pixel arrives. On an
    // accept the write address (col_q) always differs from the read address (col_d).
    assign col_new[K-1] = pix_in;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic signed [15:0] mem [IN_W];
            logic signed [15:0] rd_q;

            // Shift the column down one buffer and prefetch the next column.
            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_q] <= col_new[K-1-gi];
                end
                rd_q <= mem[col_d];
            end

            assign col_new[K-2-gi] = rd_q;
        end
    endgenerate

    // Multipliers: 32-bit signed products, one per tap.
    generate
        for (gi = 0; gi < NTAP; gi++) begin : g_tap
            assign prod[gi] = 32'(win_q[gi]) * 32'(w_q[gi]);
        end
    endgenerate

    // Control FSM and raster counters: next-state logic.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        load_cfg = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    col_d    = '0;
                    row_d    = '0;
                    load_cfg = 1'b1;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (col_q == COL_W'(IN_W - 1)) begin
                        col_d = '0;
                        row_d = (row_q == ROW_W'(IN_H - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (last_pix) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the last result is handed over, so done follows it directly.
                if (!wv_q && !v1_q && (!v2_q || out_ready)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Kernel and bias are frozen for the whole frame at start.
    always_ff @(posedge clk) begin
        if (load_cfg) begin
            for (int i = 0; i < NTAP; i++) begin
                w_q[i] <= w_in[i];
            end
            bias_q <= bias;
        end
    end

    // Window shift register: shift left and load the new column on the right.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r*K+c] <= win_q[r*K+c+1];
                end
                win_q[r*K+K-1] <= col_new[r];
            end
        end
    end

    // Adder tree: bias aligned to the product scale, plus all taps.
    always_comb begin
        sum_d = SW'(bias_q) <<< FRAC;
        for (int i = 0; i < NTAP; i++) begin
            sum_d = sum_d + SW'(prod[i]);
        end
    end

    // Rescale (floor), saturate to 16 bits, then optionally rectify.
    always_comb begin
        shifted = sum_q >>> FRAC;
        if (shifted > SAT_MAX) begin
            sat = 16'sh7FFF;
        end else if (shifted < SAT_MIN) begin
            sat = 16'sh8000;
        end else begin
            sat = shifted[15:0];
        end
`ifdef CONV_RELU_EN
        act_d = sat[15] ? 16'sd0 : sat;
`else
        act_d = sat;
`endif
    end

    // Pipeline registers: window-valid flag, S1 (sum) and S2 (output pixel).
    always_ff @(posedge clk) begin
        if (rst) begin
            wv_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            sum_q     <= '0;
            out_pix_q <= '0;
        end else if (advance) begin
            wv_q <= win_hit;
            v1_q <= wv_q;
            v2_q <= v1_q;
            if (wv_q) begin
                sum_q <= sum_d;
            end
            if (v1_q) begin
                out_pix_q <= act_d;
            end
        end
    end

endmodule
